eq_run_ctrl: RTL and testbench
==============================

# eq_run_ctrl

Controller that sequences a timed search for a run of consecutive equal samples on the `w1`/`w2` input pair. Software or an upstream FSM issues a one-cycle `start` with a window length. The block then watches up to that many cycles for `RUN_LEN` back-to-back cycles where `w1 == w2`, and reports the outcome with a `done`/`hit` pulse. It sits between the command logic and the two-line compare input, and owns arming, windowing, abort and result reporting for that resource.

## Interface
Parameters:
- `RUN_LEN`, default 4: consecutive equal cycles required for a hit. Legal range 1..15.
- `WIN_W`, default 8: width of the window length and window counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `w1` in 1: compare input A.
- `w2` in 1: compare input B.
- `start` in 1: one-cycle search request. Honoured only in IDLE.
- `abort` in 1: cancels an active search.
- `win_len` in `WIN_W`: window length in cycles. Sampled only when `start` is accepted.
- `busy` out 1: high in ARMED and DONE.
- `done` out 1: one-cycle completion pulse.
- `hit` out 1: result, valid only while `done` = 1. 1 = run found.
- `run_cnt` out 4: current consecutive-equal count, for debug.
- `hit_cnt` out 8: only present with `EQ_RUN_HITCNT_EN`.

## Operation
- Three states: IDLE, ARMED, DONE.
- Reset, or `reset` asserted in any state including mid-search:
  - state goes to IDLE;
  - `busy`, `done`, `hit` and `run_cnt` go to 0;
  - the internal window counter goes to 0;
  - `hit_cnt` goes to 0.
- IDLE:
  - `start` = 1 latches `win_len` into the window counter, clears `run_cnt`, and moves to ARMED.
  - If `win_len` = 0, go directly to DONE with `hit` = 0 and no sampling.
- ARMED, evaluated every cycle:
  - `w1 == w2`: `run_cnt` increments.
  - `w1 != w2`: `run_cnt` clears to 0.
  - The window counter decrements by 1.
- Hit: on an equal cycle where `run_cnt` + 1 == `RUN_LEN`, move to DONE with `hit` = 1.
- Timeout: otherwise, if the window counter == 1, move to DONE with `hit` = 0.
- Priority when hit and timeout fall on the same cycle: hit wins.
- `abort` = 1 in ARMED: go to IDLE, clear `run_cnt`, no `done` pulse.
  - `abort` has priority over hit and timeout in the same cycle.
  - `abort` is ignored in IDLE and DONE.
- DONE: `done` = 1 and `hit` is held for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored while `busy` = 1, including in DONE. No queuing.
- `run_cnt` saturates at `RUN_LEN` and never wraps.
- The window counter never underflows.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` accepted at edge 0: ARMED sample cycles are 1..`win_len`.
- Fastest hit, `w1 == w2` from cycle 1: `done`/`hit` high in cycle `RUN_LEN` + 1.
- Timeout: `done` high in cycle `win_len` + 1 with `hit` = 0.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Earliest next `start` is accepted one cycle after `done`.

## Configuration
- Macro: `EQ_RUN_HITCNT_EN`.
- Defined:
  - `hit_cnt` port exists.
  - It is an 8-bit counter of completions with `hit` = 1.
  - It increments in the `done` cycle and saturates at 255.
  - It is cleared only by `reset`.
- Undefined: `hit_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
Use `RUN_LEN` = 4 and `WIN_W` = 8 unless stated.
- Hit: `start` with `win_len` = 10, then `w1 = w2 = 1` held → `done` = 1, `hit` = 1 in cycle 5; `busy` high in cycles 1-5.
- Broken run then timeout: `win_len` = 6, equality pattern E,E,E,N,E,E → `done` in cycle 7 with `hit` = 0; `run_cnt` reads 0 after the N cycle.
- Boundary: `win_len` = 4 with all-equal inputs → hit and timeout coincide, `hit` = 1 in cycle 5. `win_len` = 0 → `done` in cycle 1, `hit` = 0.
- Abort and start-while-busy:
  - `abort` in cycle 3 → IDLE, no `done`.
  - `start` in cycles 2 and in the `done` cycle of another search → ignored, `win_len` not re-latched.
- Reset mid-search: `reset` = 1 in cycle 2 → next cycle `busy` = `done` = `hit` = `run_cnt` = 0. A fresh `start` then behaves as in the first scenario.
- With `EQ_RUN_HITCNT_EN`: three hits and one timeout → `hit_cnt` = 3. After 260 hits → `hit_cnt` = 255.

Source files
------------

// File: rtl/eq_run_if.sv
// Command/compare/result bundle for eq_run_ctrl.
// The hit_cnt signal exists only when EQ_RUN_HITCNT_EN is defined.
interface eq_run_if #(
    parameter int WIN_W = 8
);
    logic             w1;
    logic             w2;
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic             hit;
    logic [3:0]       run_cnt;
`ifdef EQ_RUN_HITCNT_EN
    logic [7:0]       hit_cnt;
`endif

    // start is a single-cycle request with no ready; it is accepted only when busy = 0.
    // done is a single-cycle pulse and hit is meaningful only while done = 1.
    modport master (
        output w1, w2, start, abort, win_len,
`ifdef EQ_RUN_HITCNT_EN
        input  hit_cnt,
`endif
        input  busy, done, hit, run_cnt
    );

    modport slave (
        input  w1, w2, start, abort, win_len,
`ifdef EQ_RUN_HITCNT_EN
        output hit_cnt,
`endif
        output busy, done, hit, run_cnt
    );
endinterface

// File: rtl/eq_run_ctrl.sv
// Windowed search for RUN_LEN consecutive cycles with w1 == w2, reported by a done/hit pulse.
// Optional EQ_RUN_HITCNT_EN adds a saturating count of successful searches on hit_cnt.
module eq_run_ctrl #(
    parameter int RUN_LEN = 4,
    parameter int WIN_W   = 8
) (
    input  logic      clk,
    input  logic      reset,
    eq_run_if.slave   bus
);
    localparam logic [4:0] RUN_LEN_C = 5'(RUN_LEN);
    localparam logic [3:0] RUN_MAX   = 4'(RUN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIN_W-1:0] r_win_cnt;
    logic [3:0]       r_run_cnt;
    logic             r_hit;
    logic             w_eq;
    logic             w_hit;
    logic             w_timeout;
    logic [4:0]       w_run_inc;

    assign w_eq      = (bus.w1 == bus.w2);
    assign w_run_inc = {1'b0, r_run_cnt} + 5'd1;
    assign w_hit     = w_eq && (w_run_inc == RUN_LEN_C);
    assign w_timeout = (r_win_cnt == WIN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // abort outranks hit, and hit outranks timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.win_len == '0) ? S_DONE : S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (w_hit || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_run_cnt <= '0;
            r_hit     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_win_cnt <= bus.win_len;
                        r_run_cnt <= '0;
                        r_hit     <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (bus.abort) begin
                        r_win_cnt <= '0;
                        r_run_cnt <= '0;
                        r_hit     <= 1'b0;
                    end else begin
                        if (!w_eq) begin
                            r_run_cnt <= '0;
                        end else if (r_run_cnt != RUN_MAX) begin
                            r_run_cnt <= w_run_inc[3:0];
                        end
                        if (r_win_cnt != '0) begin
                            r_win_cnt <= r_win_cnt - WIN_W'(1);
                        end
                        r_hit <= w_hit;
                    end
                end
                default: r_hit <= 1'b0;
            endcase
        end
    end

`ifdef EQ_RUN_HITCNT_EN
    logic [7:0] r_hit_cnt;

    // Counts on the edge that enters DONE with a hit, so the new value is visible during done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if ((r_state == S_ARMED) && !bus.abort && w_hit && (r_hit_cnt != 8'hFF)) begin
            r_hit_cnt <= r_hit_cnt + 8'd1;
        end
    end

    assign bus.hit_cnt = r_hit_cnt;
`endif

    always_comb begin
        bus.busy    = (r_state != S_IDLE);
        bus.done    = (r_state == S_DONE);
        bus.hit     = (r_state == S_DONE) && r_hit;
        bus.run_cnt = r_run_cnt;
    end
endmodule

// File: tb/tb_eq_run_ctrl.sv
// Directed bench for eq_run_ctrl (RUN_LEN = 4, WIN_W = 8): per-cycle vector table plus long-window and hit counter sequences.
module tb_eq_run_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    eq_run_if #(.WIN_W(8)) bus ();

    eq_run_ctrl #(.RUN_LEN(4), .WIN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       abort;
        logic       w1;
        logic       w2;
        logic [7:0] win;
        logic       e_busy;
        logic       e_done;
        logic       e_hit;
        logic [3:0] e_run;
        logic       chk_run;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic st, input logic ab, input logic a,
                           input logic b, input logic [7:0] win, input logic eb,
                           input logic ed, input logic eh, input logic [3:0] er,
                           input logic cr);
        vec_t v;
        v.rst = rst; v.start = st; v.abort = ab; v.w1 = a; v.w2 = b; v.win = win;
        v.e_busy = eb; v.e_done = ed; v.e_hit = eh; v.e_run = er; v.chk_run = cr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Starts a search with a constant equal/unequal input pattern; edges counts clock edges after acceptance until done.
    task automatic do_search(input logic [7:0] win, input logic eq, output int edges,
                             output logic got_done, output logic got_hit);
        bus.start   = 1'b1;
        bus.win_len = win;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.w1    = 1'b0;
        bus.w2    = ~eq;
        edges     = 0;
        while (!bus.done && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
        end
        got_done = bus.done;
        got_hit  = bus.hit;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   edges;
        logic got_done;
        logic got_hit;

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.w1      = 1'b0;
        bus.w2      = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.win_len = '0;

        //      rst st ab w1 w2 win  busy done hit run chk
        add_vec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        // hit, win 10, all equal
        add_vec(0, 1, 0, 0, 0, 10,  1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 3, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 1, 1, 4, 1);
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // broken run then timeout, win 6; start in cycle 2 and in done cycle ignored
        add_vec(0, 1, 0, 0, 0, 6,   1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 1, 0, 0, 0, 20,  1, 0, 0, 2, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 3, 1);
        add_vec(0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 1, 0, 2, 1);
        add_vec(0, 1, 0, 1, 1, 2,   0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        // hit and timeout coincide, win 4
        add_vec(0, 1, 0, 1, 1, 4,   1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 3, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 1, 1, 4, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        // win 0: done immediately, no hit
        add_vec(0, 1, 0, 1, 1, 0,   1, 1, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        // abort in cycle 3
        add_vec(0, 1, 0, 0, 0, 10,  1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 1);
        add_vec(0, 0, 1, 1, 1, 0,   0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        // abort beats hit
        add_vec(0, 1, 0, 0, 0, 10,  1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 3, 1);
        add_vec(0, 0, 1, 1, 1, 0,   0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        // abort ignored in IDLE, then reset mid-search in cycle 2
        add_vec(0, 1, 1, 0, 0, 10,  1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        // fresh search after reset
        add_vec(0, 1, 0, 0, 0, 10,  1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 0, 0, 3, 1);
        add_vec(0, 0, 0, 1, 1, 0,   1, 1, 1, 4, 1);
        add_vec(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            bus.start   = vecs[i].start;
            bus.abort   = vecs[i].abort;
            bus.w1      = vecs[i].w1;
            bus.w2      = vecs[i].w2;
            bus.win_len = vecs[i].win;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), int'(bus.done), int'(vecs[i].e_done));
            check($sformatf("vec%0d_hit", i), int'(bus.hit), int'(vecs[i].e_hit));
            if (vecs[i].chk_run) begin
                check($sformatf("vec%0d_run_cnt", i), int'(bus.run_cnt), int'(vecs[i].e_run));
            end
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // full-width window: timeout lands on cycle 256
        do_search(8'd255, 1'b0, edges, got_done, got_hit);
        check("long_to_done", int'(got_done), 1);
        check("long_to_edges", edges, 255);
        check("long_to_hit", int'(got_hit), 0);

        do_search(8'd10, 1'b1, edges, got_done, got_hit);
        check("task_hit_done", int'(got_done), 1);
        check("task_hit_edges", edges, 4);
        check("task_hit_hit", int'(got_hit), 1);

`ifdef EQ_RUN_HITCNT_EN
        do_reset();
        check("hitcnt_reset", int'(bus.hit_cnt), 0);
        for (int k = 0; k < 3; k++) begin
            do_search(8'd10, 1'b1, edges, got_done, got_hit);
        end
        do_search(8'd5, 1'b0, edges, got_done, got_hit);
        check("hitcnt_timeout_hit", int'(got_hit), 0);
        check("hitcnt_three", int'(bus.hit_cnt), 3);
        for (int k = 0; k < 257; k++) begin
            do_search(8'd10, 1'b1, edges, got_done, got_hit);
        end
        check("hitcnt_sat", int'(bus.hit_cnt), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
